// File: rtl/tile_fetch_scheduler.sv
// Walks a frame in 8x8 tile order, streams each tile's 64 pixels through a
// 2-entry credit-controlled FIFO, then waits for the tile buffer to drain.
module tile_fetch_scheduler #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_base_addr,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [31:0]       i_rd_data,
  output logic [31:0]       m_axis_data,
  output logic              m_axis_valid,
  input  logic              m_axis_ready,
  input  logic              i_tile_done,
  output logic [7:0]        o_tile_x,
  output logic [7:0]        o_tile_y,
  output logic              o_busy,
  output logic              o_frame_done
);

  localparam int TILES_X = IMG_W / 8;
  localparam int TILES_Y = IMG_H / 8;
  localparam int EW      = (ADDR_W > 32) ? ADDR_W : 32;
  localparam logic [7:0] TX_LAST = 8'(TILES_X - 1);
  localparam logic [7:0] TY_LAST = 8'(TILES_Y - 1);

  generate
    if ((IMG_W % 8) != 0 || (IMG_H % 8) != 0 || IMG_W < 8 || IMG_H < 8 ||
        TILES_X > 256 || TILES_Y > 256) begin : g_bad_geometry
      $error("tile_fetch_scheduler: IMG_W/IMG_H must be multiples of 8 with at most 256 tiles per axis");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_NEXT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [7:0]          tile_x_q, tile_x_d;
  logic [7:0]          tile_y_q, tile_y_d;
  logic [6:0]          rd_pix_q, rd_pix_d;
  logic [6:0]          beat_q, beat_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_pend_q, rd_pend_d;
  logic [23:0]         fifo0_q, fifo0_d;
  logic [23:0]         fifo1_q, fifo1_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          fifo_cnt_q, fifo_cnt_d;
  logic                done_seen_q, done_seen_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q, busy_d;

  logic                valid;
  logic                pop;
  logic                push;
  logic [2:0]          occ;
  logic                credit;
  logic                last_tile;
  logic                unused_rd_hi;

  assign unused_rd_hi = ^i_rd_data[31:24];

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [7:0] tx,
                                                 input logic [7:0] ty,
                                                 input logic [5:0] pix);
    logic [EW-1:0] sum;
    sum = EW'(base) + EW'({ty, pix[5:3]}) * EW'(IMG_W) + EW'({tx, pix[2:0]});
    return sum[ADDR_W-1:0];
  endfunction

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    tile_x_d     = tile_x_q;
    tile_y_d     = tile_y_q;
    rd_pix_d     = rd_pix_q;
    beat_d       = beat_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_pend_d    = rd_en_q;
    fifo0_d      = fifo0_q;
    fifo1_d      = fifo1_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    done_seen_d  = done_seen_q;
    frame_done_d = 1'b0;

    valid     = (fifo_cnt_q != 2'd0);
    pop       = valid && m_axis_ready;
    push      = rd_pend_q;
    last_tile = (tile_x_q == TX_LAST) && (tile_y_q == TY_LAST);

    // Credits cover FIFO contents plus both read pipeline stages, so a read
    // issued now always has a slot when its data lands two cycles later.
    occ    = 3'(fifo_cnt_q) + 3'(rd_en_q) + 3'(rd_pend_q);
    credit = (occ < 3'd2) || (pop && occ == 3'd2);

    if (push) begin
      if (wr_ptr_q) fifo1_d = i_rd_data[23:0];
      else          fifo0_d = i_rd_data[23:0];
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + 2'(push) - 2'(pop);

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          base_d      = i_base_addr;
          tile_x_d    = '0;
          tile_y_d    = '0;
          rd_en_d     = 1'b1;
          rd_addr_d   = i_base_addr;
          rd_pix_d    = 7'd1;
          beat_d      = '0;
          done_seen_d = 1'b0;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        if (i_tile_done) done_seen_d = 1'b1;
        if (rd_pix_q < 7'd64 && credit) begin
          rd_en_d   = 1'b1;
          rd_addr_d = pix_addr(base_q, tile_x_q, tile_y_q, rd_pix_q[5:0]);
          rd_pix_d  = rd_pix_q + 7'd1;
        end
        if (pop) begin
          beat_d = beat_q + 7'd1;
          if (beat_q == 7'd63) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (i_tile_done || done_seen_q) begin
          done_seen_d = 1'b0;
          state_d     = S_NEXT;
        end
      end
      S_NEXT: begin
        if (last_tile) begin
          frame_done_d = 1'b1;
          state_d      = S_DONE;
        end else begin
          if (tile_x_q == TX_LAST) begin
            tile_x_d = '0;
            tile_y_d = tile_y_q + 8'd1;
          end else begin
            tile_x_d = tile_x_q + 8'd1;
          end
          rd_en_d   = 1'b1;
          rd_addr_d = pix_addr(base_q, tile_x_d, tile_y_d, 6'd0);
          rd_pix_d  = 7'd1;
          beat_d    = '0;
          state_d   = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && i_abort) begin
      state_d      = S_IDLE;
      rd_en_d      = 1'b0;
      rd_pend_d    = 1'b0;
      fifo_cnt_d   = '0;
      wr_ptr_d     = 1'b0;
      rd_ptr_d     = 1'b0;
      done_seen_d  = 1'b0;
      frame_done_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      tile_x_q     <= '0;
      tile_y_q     <= '0;
      rd_pix_q     <= '0;
      beat_q       <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      rd_pend_q    <= 1'b0;
      fifo0_q      <= '0;
      fifo1_q      <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      fifo_cnt_q   <= '0;
      done_seen_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      tile_x_q     <= tile_x_d;
      tile_y_q     <= tile_y_d;
      rd_pix_q     <= rd_pix_d;
      beat_q       <= beat_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      rd_pend_q    <= rd_pend_d;
      fifo0_q      <= fifo0_d;
      fifo1_q      <= fifo1_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      done_seen_q  <= done_seen_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign o_rd_en      = rd_en_q;
  assign o_rd_addr    = rd_addr_q;
  assign m_axis_valid = valid;
  assign m_axis_data  = valid ? {8'h00, (rd_ptr_q ? fifo1_q : fifo0_q)} : '0;
  assign o_tile_x     = tile_x_q;
  assign o_tile_y     = tile_y_q;
  assign o_busy       = busy_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_tile_fetch_scheduler.sv
// Directed bench for tile_fetch_scheduler: 16x8 frame instance plus an 8x8
// instance with an 8-bit address space for the wrap case.
module tb_tile_fetch_scheduler;

  logic        clk = 1'b0;
  logic        i_rst;
  always #5 clk = ~clk;

  logic        i_start, i_abort, o_rd_en, m_axis_valid, m_axis_ready;
  logic        i_tile_done, o_busy, o_frame_done;
  logic [19:0] i_base_addr, o_rd_addr;
  logic [31:0] i_rd_data, m_axis_data;
  logic [7:0]  o_tile_x, o_tile_y;

  logic        start_b, abort_b, rd_en_b, valid_b, ready_b, done_b, busy_b, fd_b;
  logic [7:0]  base_b, rd_addr_b, tx_b, ty_b;
  logic [31:0] rd_data_b, data_b;

  tile_fetch_scheduler #(.IMG_W(16), .IMG_H(8), .ADDR_W(20)) dut_a (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_base_addr(i_base_addr), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .i_rd_data(i_rd_data), .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
    .m_axis_ready(m_axis_ready), .i_tile_done(i_tile_done), .o_tile_x(o_tile_x),
    .o_tile_y(o_tile_y), .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  tile_fetch_scheduler #(.IMG_W(8), .IMG_H(8), .ADDR_W(8)) dut_b (
    .i_clk(clk), .i_rst(i_rst), .i_start(start_b), .i_abort(abort_b),
    .i_base_addr(base_b), .o_rd_en(rd_en_b), .o_rd_addr(rd_addr_b),
    .i_rd_data(rd_data_b), .m_axis_data(data_b), .m_axis_valid(valid_b),
    .m_axis_ready(ready_b), .i_tile_done(done_b), .o_tile_x(tx_b),
    .o_tile_y(ty_b), .o_busy(busy_b), .o_frame_done(fd_b)
  );

  // Pixel memory: word = address, with junk in the top byte; junk when not read.
  always @(posedge clk) begin
    i_rd_data <= o_rd_en ? {8'hEE, 4'h0, o_rd_addr} : 32'hDEAD_BEEF;
    rd_data_b <= rd_en_b ? {8'hEE, 16'h0, rd_addr_b} : 32'hDEAD_BEEF;
  end

  int checks = 0;
  int failures = 0;
  int total_beats = 0;
  int t_beats, t_nrd, t_cyc, t_first;
  logic prev_v, prev_r;
  logic [31:0] prev_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] exp_a(input logic [19:0] base, input int tile, input int p);
    return 20'(32'(base) + (p / 8) * 16 + tile * 8 + (p % 8));
  endfunction

  task automatic new_tile();
    t_beats = 0; t_nrd = 0; t_cyc = 0; t_first = -1;
    prev_v = 1'b0; prev_r = 1'b1; prev_d = '0;
  endtask

  // Runs instance A until `stop` beats of the current tile have been accepted.
  task automatic stream(input int tile, input logic [19:0] base, input int stop,
                        input bit bp, input bit early);
    int cyc;
    logic v, r;
    logic [31:0] d;
    cyc = 0;
    while (t_beats < stop && cyc < 2000) begin
      v = m_axis_valid;
      d = m_axis_data;
      if (t_cyc == 0) begin
        chk("tile_x", 32'(o_tile_x), 32'(tile));
        chk("tile_y", 32'(o_tile_y), 32'd0);
      end
      if (prev_v && !prev_r) begin
        chk("hold_valid", 32'(v), 32'd1);
        chk("hold_data", d, prev_d);
      end
      if (v && t_first < 0) begin
        t_first = t_cyc;
        chk("first_valid_latency", 32'(t_cyc), 32'd2);
      end
      if (o_rd_en) begin
        chk("rd_count", 32'(t_nrd < 64), 32'd1);
        chk("rd_addr", 32'(o_rd_addr), 32'(exp_a(base, tile, t_nrd)));
        t_nrd++;
      end
      chk("outstanding_le2", 32'((t_nrd - t_beats) <= 2), 32'd1);
      chk("no_frame_done", 32'(o_frame_done), 32'd0);
      r = bp ? ((t_cyc % 10) >= 3) : 1'b1;
      m_axis_ready = r;
      if (v && r) begin
        chk("beat_data", d, {12'h000, exp_a(base, tile, t_beats)});
        t_beats++;
        total_beats++;
        if (early && t_beats == 64) i_tile_done = 1'b1;
      end
      prev_v = v; prev_r = r; prev_d = d;
      t_cyc++;
      cyc++;
      tick();
      i_start = 1'b0;
      i_tile_done = 1'b0;
    end
    chk("stream_timeout", 32'(t_beats >= stop), 32'd1);
  endtask

  task automatic drain_wait();
    for (int i = 0; i < 10; i++) begin
      chk("drain_valid", 32'(m_axis_valid), 32'd0);
      chk("drain_busy", 32'(o_busy), 32'd1);
      chk("drain_rd_en", 32'(o_rd_en), 32'd0);
      tick();
    end
    i_tile_done = 1'b1;
    tick();
    i_tile_done = 1'b0;
    chk("next_valid", 32'(m_axis_valid), 32'd0);
    chk("next_frame_done", 32'(o_frame_done), 32'd0);
  endtask

  task automatic advance_tile();
    drain_wait();
    tick();
    new_tile();
  endtask

  task automatic finish_frame();
    drain_wait();
    tick();
    chk("done_pulse", 32'(o_frame_done), 32'd1);
    chk("done_busy", 32'(o_busy), 32'd1);
    tick();
    chk("after_done_pulse", 32'(o_frame_done), 32'd0);
    chk("after_done_busy", 32'(o_busy), 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rd_en", 32'(o_rd_en), 32'd0);
    chk("rst_rd_addr", 32'(o_rd_addr), 32'd0);
    chk("rst_data", m_axis_data, 32'd0);
    chk("rst_valid", 32'(m_axis_valid), 32'd0);
    chk("rst_tile_x", 32'(o_tile_x), 32'd0);
    chk("rst_tile_y", 32'(o_tile_y), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_frame_done", 32'(o_frame_done), 32'd0);
  endtask

  initial begin
    int nb, nr;
    i_rst = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_base_addr = '0;
    m_axis_ready = 1'b1; i_tile_done = 1'b0;
    start_b = 1'b0; abort_b = 1'b0; base_b = '0; ready_b = 1'b1; done_b = 1'b0;
    tick(); tick(); tick();
    chk_reset_outputs();
    chk("rst_b_busy", 32'(busy_b), 32'd0);
    i_rst = 1'b1;
    tick();
    chk("idle_busy", 32'(o_busy), 32'd0);

    // Frame 1: ready held high, two tiles, 128 beats in total.
    i_base_addr = 20'h00100; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("start_busy", 32'(o_busy), 32'd1);
    new_tile();
    stream(0, 20'h00100, 64, 1'b0, 1'b0);
    advance_tile();
    stream(1, 20'h00100, 64, 1'b0, 1'b0);
    finish_frame();
    chk("total_beats", 32'(total_beats), 32'd128);

    // Frame 2: 30% backpressure, tile_done arrives with the last beat of tile 0.
    i_base_addr = 20'h002A0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    new_tile();
    stream(0, 20'h002A0, 64, 1'b1, 1'b1);
    chk("early_drain_valid", 32'(m_axis_valid), 32'd0);
    tick();
    chk("early_next_rd_en", 32'(o_rd_en), 32'd0);
    chk("early_next_busy", 32'(o_busy), 32'd1);
    tick();
    new_tile();
    stream(1, 20'h002A0, 64, 1'b1, 1'b0);
    finish_frame();

    // Frame 3: abort at beat 20 of tile 1, then a clean restart.
    i_base_addr = 20'h00300; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    new_tile();
    stream(0, 20'h00300, 64, 1'b0, 1'b0);
    advance_tile();
    stream(1, 20'h00300, 20, 1'b0, 1'b0);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("abort_valid", 32'(m_axis_valid), 32'd0);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_rd_en", 32'(o_rd_en), 32'd0);
    chk("abort_frame_done", 32'(o_frame_done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_abort_valid", 32'(m_axis_valid), 32'd0);
      chk("post_abort_frame_done", 32'(o_frame_done), 32'd0);
    end
    i_base_addr = 20'h00100; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    new_tile();
    stream(0, 20'h00100, 10, 1'b1, 1'b0);

    // Start pulse in FETCH must be ignored; the stream continues unchanged.
    i_base_addr = 20'h00500; i_start = 1'b1;
    stream(0, 20'h00100, 30, 1'b1, 1'b0);
    chk("ignored_start_busy", 32'(o_busy), 32'd1);

    // Reset mid-tile, then tile_done in IDLE must not wake the scheduler.
    i_rst = 1'b0;
    tick();
    chk_reset_outputs();
    tick();
    i_rst = 1'b1;
    i_tile_done = 1'b1;
    tick();
    i_tile_done = 1'b0;
    chk("idle_done_busy", 32'(o_busy), 32'd0);
    tick();
    chk("idle_done_valid", 32'(m_axis_valid), 32'd0);
    chk("idle_done_rd_en", 32'(o_rd_en), 32'd0);

    // Address wrap on the 8-bit instance: row 1 lands on 0x00..0x07.
    base_b = 8'hF8; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    nb = 0; nr = 0;
    for (int c = 0; c < 400 && nb < 64; c++) begin
      if (rd_en_b) begin
        chk("b_rd_addr", 32'(rd_addr_b), (32'hF8 + (nr / 8) * 8 + (nr % 8)) & 32'hFF);
        nr++;
      end
      if (valid_b) begin
        chk("b_data", data_b, (32'hF8 + (nb / 8) * 8 + (nb % 8)) & 32'hFF);
        nb++;
      end
      tick();
    end
    chk("b_beats", 32'(nb), 32'd64);
    done_b = 1'b1;
    tick();
    done_b = 1'b0;
    chk("b_next_frame_done", 32'(fd_b), 32'd0);
    tick();
    chk("b_frame_done", 32'(fd_b), 32'd1);
    tick();
    chk("b_idle_busy", 32'(busy_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
